fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the dual-clock FIFO. It lives in the write clock domain and produces the gray-coded write pointer that the read-domain pointer synchronizer captures. It takes the read pointer, already synchronized into the write domain, and from it derives full, almost-full, fill level and overflow status. It also drives the write port of the dual-port RAM (address and write enable).

---
 rtl/fifo_wr_ctrl.sv | 83 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side gray pointer, flag and RAM-write controller of a dual-clock FIFO.
// Define FIFO_WR_PTR_CHECK_EN to add the sticky synchronized-read-pointer sanity check (ptr_err).
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH-4
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
  input  logic                  clr_ovf,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  mem_we,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow,
  output logic                  ptr_err
);
  localparam int P = ADDR_WIDTH+1;
  localparam logic [P-1:0] AF = P'(AFULL_THRESH);
  function automatic logic [P-1:0] g2b(input logic [P-1:0] g);
    for (int i = 0; i < P; i++) g2b[i] = ^(g >> i);
  endfunction
  logic [P-1:0] wr_bin_q, wr_bin_d, wr_ptr_q, wr_ptr_d, wr_level_q, wr_level_d, rd_bin;
  logic full_q, full_d, almost_full_q, almost_full_d, overflow_q, overflow_d;
  assign mem_we = wr_en & ~full_q & ~rst;
  assign rd_bin = g2b(rd_ptr_sync);
  always_comb begin
    wr_bin_d      = wr_bin_q + {{(P-1){1'b0}}, mem_we};
    wr_ptr_d      = wr_bin_d ^ (wr_bin_d >> 1);
    wr_level_d    = wr_bin_d - rd_bin;
    almost_full_d = wr_level_d >= AF;
    full_d        = wr_ptr_d == {~rd_ptr_sync[P-1:P-2], rd_ptr_sync[P-3:0]};
    overflow_d    = (wr_en & full_q) | (overflow_q & ~clr_ovf);
  end
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_bin_q      <= '0;
      wr_ptr_q      <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end
  assign wr_ptr      = wr_ptr_q;
  assign wr_addr     = wr_bin_q[ADDR_WIDTH-1:0];
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_level    = wr_level_q;
  assign overflow    = overflow_q;
`ifdef FIFO_WR_PTR_CHECK_EN
  localparam logic [P-1:0] DEPTH = P'(2**ADDR_WIDTH);
  logic [P-1:0] prev_q, rd_step;
  logic ptr_err_q, ptr_err_d;
  // a legal synchronized gray pointer moves by one bit and only forward
  always_comb begin
    rd_step   = rd_bin - g2b(prev_q);
    ptr_err_d = ptr_err_q | ($countones(rd_ptr_sync ^ prev_q) > 1) | (rd_step > DEPTH);
  end
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      prev_q    <= '0;
      ptr_err_q <= 1'b0;
    end else begin
      prev_q    <= rd_ptr_sync;
      ptr_err_q <= ptr_err_d;
    end
  end
  assign ptr_err = ptr_err_q;
`else
  assign ptr_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed self-checking bench for fifo_wr_ctrl with ADDR_WIDTH=2, AFULL_THRESH=3.
module tb_fifo_wr_ctrl;
  logic       wr_clk = 1'b0;
  logic       rst, wr_en, clr_ovf;
  logic [2:0] rd_ptr_sync, wr_ptr, wr_level;
  logic [1:0] wr_addr;
  logic       mem_we, full, almost_full, overflow, ptr_err;
  int n_tests = 0, n_fail = 0;
  logic [2:0] exp_bin, rd_b;
`ifdef FIFO_WR_PTR_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  fifo_wr_ctrl #(.ADDR_WIDTH(2), .AFULL_THRESH(3)) dut (
    .wr_clk(wr_clk), .rst(rst), .wr_en(wr_en), .rd_ptr_sync(rd_ptr_sync), .clr_ovf(clr_ovf),
    .wr_ptr(wr_ptr), .wr_addr(wr_addr), .mem_we(mem_we), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow), .ptr_err(ptr_err)
  );
  always #5 wr_clk = ~wr_clk;
  function automatic logic [2:0] gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge wr_clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic [2:0] ptr, input logic [2:0] lvl,
                         input logic f, input logic af, input logic ov);
    chk({tag, ".wr_ptr"}, 32'(wr_ptr), 32'(ptr));
    chk({tag, ".wr_level"}, 32'(wr_level), 32'(lvl));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
  endtask
  initial begin
    rst = 1'b1; wr_en = 1'b1; clr_ovf = 1'b0; rd_ptr_sync = 3'b000;
    #1;
    chk("rst_mem_we_pre", 32'(mem_we), 0);
    step;
    chk("rst_mem_we", 32'(mem_we), 0);
    step;
    chk_all("rst", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_mem_we2", 32'(mem_we), 0);
    chk("rst_ptr_err", 32'(ptr_err), 0);
    rst = 1'b0;
    #1;
    chk("w1_addr", 32'(wr_addr), 0);
    chk("w1_we", 32'(mem_we), 1);
    step;
    chk_all("w1", 3'b001, 3'd1, 1'b0, 1'b0, 1'b0);
    chk("w2_addr", 32'(wr_addr), 1);
    step;
    chk_all("w2", 3'b011, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("w3_addr", 32'(wr_addr), 2);
    step;
    chk_all("w3", 3'b010, 3'd3, 1'b0, 1'b1, 1'b0);
    chk("w4_addr", 32'(wr_addr), 3);
    chk("w4_we", 32'(mem_we), 1);
    step;
    chk_all("w4", 3'b110, 3'd4, 1'b1, 1'b1, 1'b0);
    chk("w5_we", 32'(mem_we), 0);
    step;
    chk_all("w5_drop", 3'b110, 3'd4, 1'b1, 1'b1, 1'b1);
    wr_en = 1'b0; rd_ptr_sync = 3'b001;
    step;
    chk_all("rd1", 3'b110, 3'd3, 1'b0, 1'b1, 1'b1);
    clr_ovf = 1'b1;
    step;
    chk_all("clr", 3'b110, 3'd3, 1'b0, 1'b1, 1'b0);
    clr_ovf = 1'b0; wr_en = 1'b1;
    #1;
    chk("w6_addr", 32'(wr_addr), 0);
    step;
    chk_all("w6", 3'b111, 3'd4, 1'b1, 1'b1, 1'b0);
    clr_ovf = 1'b1;
    #1;
    chk("setclr_we", 32'(mem_we), 0);
    step;
    chk_all("setclr", 3'b111, 3'd4, 1'b1, 1'b1, 1'b1);
    wr_en = 1'b0; clr_ovf = 1'b0;
    rd_ptr_sync = 3'b011; step;
    rd_ptr_sync = 3'b010; step;
    rd_ptr_sync = 3'b110; step;
    chk_all("drain3", 3'b111, 3'd1, 1'b0, 1'b0, 1'b1);
    rd_ptr_sync = 3'b111; clr_ovf = 1'b1; step;
    chk_all("drain4", 3'b111, 3'd0, 1'b0, 1'b0, 1'b0);
    clr_ovf = 1'b0;
    exp_bin = 3'd5; rd_b = 3'd5;
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1;
      #1;
      chk($sformatf("wrap%0d_addr", k), 32'(wr_addr), 32'(exp_bin[1:0]));
      chk($sformatf("wrap%0d_we", k), 32'(mem_we), 1);
      step;
      exp_bin = exp_bin + 3'd1;
      chk_all($sformatf("wrap%0d_w", k), gray(exp_bin), 3'd1, 1'b0, 1'b0, 1'b0);
      wr_en = 1'b0; rd_b = rd_b + 3'd1; rd_ptr_sync = gray(rd_b);
      step;
      chk_all($sformatf("wrap%0d_r", k), gray(exp_bin), 3'd0, 1'b0, 1'b0, 1'b0);
    end
    chk("wrap_end_ptr", 32'(wr_ptr), 32'(3'b100));
    chk("pre_err", 32'(ptr_err), 0);
    rst = 1'b1; rd_ptr_sync = 3'b000;
    step;
    rst = 1'b0; rd_ptr_sync = 3'b011;
    step;
    chk("err_set", 32'(ptr_err), 32'(CHK));
    step;
    chk("err_sticky", 32'(ptr_err), 32'(CHK));
    rd_ptr_sync = 3'b010; step;
    chk("err_sticky2", 32'(ptr_err), 32'(CHK));
    rst = 1'b1; rd_ptr_sync = 3'b000;
    step;
    chk("err_rst", 32'(ptr_err), 0);
    chk_all("final_rst", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
